// File: rtl/uart_image_loader.sv
// uart_image_loader: writes UART bytes to consecutive DRAM addresses and flags done at image end.
// Optional feature macro LOADER_CHECKSUM_EN adds a mod-2^16 checksum of the bytes written.
module uart_image_loader #(
   parameter int ADDR_W    = 17,
   parameter int IMG_BYTES = 65536,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              rx_ready,
   input  logic [7:0]        rx_data,
   output logic              rx_ready_clr,
   output logic              dram_we,
   output logic [ADDR_W-1:0] dram_addr,
   output logic [7:0]        dram_din,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   byte_count,
`ifdef LOADER_CHECKSUM_EN
   output logic [15:0]       checksum,
`endif
   output logic [2:0]        state_dbg
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] WAIT_RX = 3'd1;
   localparam logic [2:0] WRITE   = 3'd2;
   localparam logic [2:0] DRAIN   = 3'd3;
   localparam logic [2:0] DONE    = 3'd4;

   localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W:0]   IMG_CNT = (ADDR_W+1)'(IMG_BYTES);

   logic [2:0]        state_q, state_d;
   logic              rx_ready_clr_q, rx_ready_clr_d;
   logic              dram_we_q, dram_we_d;
   logic [ADDR_W-1:0] dram_addr_q, dram_addr_d;
   logic [7:0]        dram_din_q, dram_din_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [ADDR_W:0]   byte_count_q, byte_count_d;
`ifdef LOADER_CHECKSUM_EN
   logic [15:0]       checksum_q, checksum_d;
`endif

   always_comb begin
      state_d        = state_q;
      rx_ready_clr_d = 1'b0;
      dram_we_d      = 1'b0;
      dram_addr_d    = dram_addr_q;
      dram_din_d     = dram_din_q;
      busy_d         = busy_q;
      done_d         = done_q;
      byte_count_d   = byte_count_q;
`ifdef LOADER_CHECKSUM_EN
      checksum_d     = checksum_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               byte_count_d = '0;
               dram_addr_d  = BASE;
               busy_d       = 1'b1;
               done_d       = 1'b0;
`ifdef LOADER_CHECKSUM_EN
               checksum_d   = 16'h0000;
`endif
               state_d      = WAIT_RX;
            end
         end
         WAIT_RX: begin
            // Write strobe and UART clear are registered, so both are high exactly while in WRITE.
            if (rx_ready) begin
               dram_din_d     = rx_data;
               dram_we_d      = 1'b1;
               rx_ready_clr_d = 1'b1;
               state_d        = WRITE;
            end
         end
         WRITE: begin
            byte_count_d = byte_count_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
            checksum_d   = checksum_q + {8'h00, dram_din_q};
`endif
            state_d      = DRAIN;
         end
         DRAIN: begin
            // Wait for the UART to drop ready so the same byte is never consumed twice.
            if (!rx_ready) begin
               if (byte_count_q == IMG_CNT) begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = DONE;
               end else begin
                  dram_addr_d = dram_addr_q + 1'b1;
                  state_d     = WAIT_RX;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         rx_ready_clr_q <= 1'b0;
         dram_we_q      <= 1'b0;
         dram_addr_q    <= BASE;
         dram_din_q     <= 8'h00;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         byte_count_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
         checksum_q     <= 16'h0000;
`endif
      end else begin
         state_q        <= state_d;
         rx_ready_clr_q <= rx_ready_clr_d;
         dram_we_q      <= dram_we_d;
         dram_addr_q    <= dram_addr_d;
         dram_din_q     <= dram_din_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         byte_count_q   <= byte_count_d;
`ifdef LOADER_CHECKSUM_EN
         checksum_q     <= checksum_d;
`endif
      end
   end

   assign rx_ready_clr = rx_ready_clr_q;
   assign dram_we      = dram_we_q;
   assign dram_addr    = dram_addr_q;
   assign dram_din     = dram_din_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign byte_count   = byte_count_q;
`ifdef LOADER_CHECKSUM_EN
   assign checksum     = checksum_q;
`endif
   assign state_dbg    = state_q;

endmodule

// File: tb/tb_uart_image_loader.sv
// Bench for uart_image_loader: a 4-byte image at base 16 (instance a) and a 1-byte image at base 5 (instance b).
module tb_uart_image_loader;

   localparam int AW      = 17;
   localparam int A_BYTES = 4;
   localparam int A_BASE  = 16;
   localparam int B_BYTES = 1;
   localparam int B_BASE  = 5;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          start_a, rx_ready_a, rx_ready_clr_a, dram_we_a, busy_a, done_a;
   logic [7:0]    rx_data_a, dram_din_a;
   logic [AW-1:0] dram_addr_a;
   logic [AW:0]   byte_count_a;
   logic [2:0]    state_dbg_a;
   logic          start_b, rx_ready_b, rx_ready_clr_b, dram_we_b, busy_b, done_b;
   logic [7:0]    rx_data_b, dram_din_b;
   logic [AW-1:0] dram_addr_b;
   logic [AW:0]   byte_count_b;
   logic [2:0]    state_dbg_b;
`ifdef LOADER_CHECKSUM_EN
   logic [15:0]   checksum_a, checksum_b;
`endif

   uart_image_loader #(.ADDR_W(AW), .IMG_BYTES(A_BYTES), .BASE_ADDR(A_BASE)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .rx_ready(rx_ready_a), .rx_data(rx_data_a),
      .rx_ready_clr(rx_ready_clr_a), .dram_we(dram_we_a), .dram_addr(dram_addr_a),
      .dram_din(dram_din_a), .busy(busy_a), .done(done_a), .byte_count(byte_count_a),
`ifdef LOADER_CHECKSUM_EN
      .checksum(checksum_a),
`endif
      .state_dbg(state_dbg_a));

   uart_image_loader #(.ADDR_W(AW), .IMG_BYTES(B_BYTES), .BASE_ADDR(B_BASE)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .rx_ready(rx_ready_b), .rx_data(rx_data_b),
      .rx_ready_clr(rx_ready_clr_b), .dram_we(dram_we_b), .dram_addr(dram_addr_b),
      .dram_din(dram_din_b), .busy(busy_b), .done(done_b), .byte_count(byte_count_b),
`ifdef LOADER_CHECKSUM_EN
      .checksum(checksum_b),
`endif
      .state_dbg(state_dbg_b));

   int checks = 0;
   int errors = 0;

   // Reference model: expected DRAM writes {addr, data}, bytes sent this load, running byte sum.
   logic [AW+7:0] exp_a_q[$];
   logic [AW+7:0] exp_b_q[$];
   int a_idx, a_sum, we_a_cnt, clr_a_cnt;
   int b_idx, we_b_cnt;
   logic [AW+7:0] mon_a_e, mon_b_e;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (rx_ready_clr_a) clr_a_cnt++;
         if (dram_we_a) begin
            we_a_cnt++;
            chk("a_write_pending", 32'(exp_a_q.size() != 0), 32'd1);
            if (exp_a_q.size() != 0) begin
               mon_a_e = exp_a_q.pop_front();
               chk("a_write_addr", 32'(dram_addr_a), 32'(mon_a_e[AW+7:8]));
               chk("a_write_data", 32'(dram_din_a), 32'(mon_a_e[7:0]));
            end
         end
         if (dram_we_b) begin
            we_b_cnt++;
            chk("b_write_pending", 32'(exp_b_q.size() != 0), 32'd1);
            if (exp_b_q.size() != 0) begin
               mon_b_e = exp_b_q.pop_front();
               chk("b_write_addr", 32'(dram_addr_b), 32'(mon_b_e[AW+7:8]));
               chk("b_write_data", 32'(dram_din_b), 32'(mon_b_e[7:0]));
            end
         end
      end
   end

   task automatic start_load_a();
      start_a = 1'b1;
      tick(1);
      start_a = 1'b0;
      a_idx = 0; a_sum = 0; we_a_cnt = 0; clr_a_cnt = 0;
      chk("a_start_busy", 32'(busy_a), 32'd1);
      chk("a_start_done", 32'(done_a), 32'd0);
      chk("a_start_count", 32'(byte_count_a), 32'd0);
      chk("a_start_addr", 32'(dram_addr_a), 32'(A_BASE));
`ifdef LOADER_CHECKSUM_EN
      chk("a_start_csum", 32'(checksum_a), 32'd0);
`endif
   endtask

   task automatic send_a(input logic [7:0] b, input int hold);
      int n;
      logic [AW-1:0] ad;
      ad = AW'(A_BASE + a_idx);
      exp_a_q.push_back({ad, b});
      a_idx++;
      a_sum += int'(b);
      rx_data_a = b;
      rx_ready_a = 1'b1;
      n = 0;
      while (rx_ready_clr_a !== 1'b1 && n < 40) begin
         tick(1);
         n++;
      end
      chk("a_clr_seen", 32'(n < 40), 32'd1);
      repeat (hold) begin
         tick(1);
         chk("a_hold_addr", 32'(dram_addr_a), 32'(ad));
         chk("a_hold_busy", 32'(busy_a), 32'd1);
      end
      rx_ready_a = 1'b0;
      rx_data_a = 8'($urandom_range(0, 255));
      tick(2 + $urandom_range(0, 3));
   endtask

   task automatic finish_a(input string tag);
      int n;
      n = 0;
      while (done_a !== 1'b1 && n < 20) begin
         tick(1);
         n++;
      end
      tick(1);
      chk({tag, "_done"}, 32'(done_a), 32'd1);
      chk({tag, "_busy"}, 32'(busy_a), 32'd0);
      chk({tag, "_count"}, 32'(byte_count_a), 32'(a_idx));
      chk({tag, "_we_cnt"}, 32'(we_a_cnt), 32'(a_idx));
      chk({tag, "_clr_cnt"}, 32'(clr_a_cnt), 32'(a_idx));
      chk({tag, "_exp_left"}, 32'(exp_a_q.size()), 32'd0);
`ifdef LOADER_CHECKSUM_EN
      chk({tag, "_csum"}, 32'(checksum_a), 32'(a_sum % 65536));
`endif
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_a_clr"}, 32'(rx_ready_clr_a), 32'd0);
      chk({tag, "_a_we"}, 32'(dram_we_a), 32'd0);
      chk({tag, "_a_addr"}, 32'(dram_addr_a), 32'(A_BASE));
      chk({tag, "_a_din"}, 32'(dram_din_a), 32'd0);
      chk({tag, "_a_busy"}, 32'(busy_a), 32'd0);
      chk({tag, "_a_done"}, 32'(done_a), 32'd0);
      chk({tag, "_a_count"}, 32'(byte_count_a), 32'd0);
      chk({tag, "_b_addr"}, 32'(dram_addr_b), 32'(B_BASE));
      chk({tag, "_b_busy"}, 32'(busy_b), 32'd0);
      chk({tag, "_b_done"}, 32'(done_b), 32'd0);
`ifdef LOADER_CHECKSUM_EN
      chk({tag, "_a_csum"}, 32'(checksum_a), 32'd0);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] dir[4];
      int n;
      rst = 1'b1;
      start_a = 1'b0; rx_ready_a = 1'b0; rx_data_a = 8'h00;
      start_b = 1'b0; rx_ready_b = 1'b0; rx_data_b = 8'h00;
      a_idx = 0; a_sum = 0; we_a_cnt = 0; clr_a_cnt = 0; b_idx = 0; we_b_cnt = 0;
      tick(2);
      check_reset_values("reset");
      rst = 1'b0;
      tick(2);

      // Directed image 0x11..0x44 at addresses 16..19.
      dir[0] = 8'h11; dir[1] = 8'h22; dir[2] = 8'h33; dir[3] = 8'h44;
      start_load_a();
      for (int i = 0; i < 4; i++) send_a(dir[i], 0);
      finish_a("t1");

      // Slow UART clear: ready held 5 cycles past the clear pulse (restarting from DONE).
      start_load_a();
      send_a(8'($urandom_range(0, 255)), 5);
      for (int i = 1; i < 4; i++) send_a(8'($urandom_range(0, 255)), (i == 3) ? 5 : 0);
      finish_a("t2");

      // Async reset after 2 of 4 bytes, then a fresh load from the base address.
      start_load_a();
      send_a(8'($urandom_range(0, 255)), 0);
      send_a(8'($urandom_range(0, 255)), 0);
      rst = 1'b1;
      #1;
      check_reset_values("midrst");
      tick(1);
      rst = 1'b0;
      exp_a_q.delete();
      tick(1);
      start_load_a();
      for (int i = 0; i < 4; i++) send_a(8'($urandom_range(0, 255)), $urandom_range(0, 2));
      finish_a("t3");

      // Start pulsed mid-load must be ignored.
      start_load_a();
      send_a(8'($urandom_range(0, 255)), 0);
      start_a = 1'b1;
      tick(1);
      start_a = 1'b0;
      chk("t4_count_after_start", 32'(byte_count_a), 32'd1);
      chk("t4_busy_after_start", 32'(busy_a), 32'd1);
      for (int i = 1; i < 4; i++) send_a(8'($urandom_range(0, 255)), 0);
      finish_a("t4");

      // Randomised loads.
      for (int k = 0; k < 3; k++) begin
         start_load_a();
         for (int i = 0; i < 4; i++) send_a(8'($urandom_range(0, 255)), $urandom_range(0, 3));
         finish_a("rand");
      end

`ifdef LOADER_CHECKSUM_EN
      start_load_a();
      send_a(8'hFF, 0); send_a(8'hFF, 0); send_a(8'h02, 0); send_a(8'h00, 0);
      finish_a("t6");
      chk("t6_csum_value", 32'(checksum_a), 32'h0200);
      tick(3);
      chk("t6_csum_stable", 32'(checksum_a), 32'h0200);
      start_load_a();
      for (int i = 0; i < 4; i++) send_a(8'($urandom_range(0, 255)), 0);
      finish_a("t6b");
`endif

      // One-byte image: start and rx_ready in the same cycle.
      exp_b_q.push_back({AW'(B_BASE), 8'hA5});
      start_b = 1'b1; rx_ready_b = 1'b1; rx_data_b = 8'hA5;
      tick(1);
      start_b = 1'b0;
      chk("t5_we_1clk", 32'(dram_we_b), 32'd0);
      chk("t5_busy_1clk", 32'(busy_b), 32'd1);
      tick(1);
      chk("t5_we_2clk", 32'(dram_we_b), 32'd1);
      chk("t5_clr_2clk", 32'(rx_ready_clr_b), 32'd1);
      rx_ready_b = 1'b0;
      n = 0;
      while (done_b !== 1'b1 && n < 20) begin
         tick(1);
         n++;
      end
      tick(1);
      chk("t5_done", 32'(done_b), 32'd1);
      chk("t5_busy", 32'(busy_b), 32'd0);
      chk("t5_count", 32'(byte_count_b), 32'd1);
      chk("t5_we_cnt", 32'(we_b_cnt), 32'd1);
      start_b = 1'b1;
      tick(1);
      start_b = 1'b0;
      chk("t5_restart_done", 32'(done_b), 32'd0);
      chk("t5_restart_busy", 32'(busy_b), 32'd1);
      chk("t5_restart_count", 32'(byte_count_b), 32'd0);
      tick($urandom_range(0, 3));
      rx_data_b = 8'($urandom_range(0, 255));
      exp_b_q.push_back({AW'(B_BASE), rx_data_b});
      rx_ready_b = 1'b1;
      n = 0;
      while (rx_ready_clr_b !== 1'b1 && n < 40) begin
         tick(1);
         n++;
      end
      rx_ready_b = 1'b0;
      n = 0;
      while (done_b !== 1'b1 && n < 20) begin
         tick(1);
         n++;
      end
      tick(1);
      chk("t5b_done", 32'(done_b), 32'd1);
      chk("t5b_count", 32'(byte_count_b), 32'd1);
      chk("t5b_we_cnt", 32'(we_b_cnt), 32'd2);
      chk("t5b_exp_left", 32'(exp_b_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
